// File: rtl/axil_reg_slave_if.sv
// AXI-Lite bus bundle between the USB bridge (master) and the register bank (slave).
interface axil_reg_slave_if;
    logic [14:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [14:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI-Lite register bank: ID, scratch, control, status, pulse and cycle counter.
// Write and read channels run independently; AW and W may arrive in any order.
module axil_reg_slave #(
    parameter logic [31:0] ID_VALUE = 32'h4C50_4434,
    parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    axil_reg_slave_if.slave    bus,
    input  logic [31:0]        status_in,
    output logic [31:0]        ctrl_out,
    output logic [31:0]        pulse_out
);

    // Word indices (byte address bits [14:2])
    localparam logic [12:0] IDX_ID      = 13'h0000;
    localparam logic [12:0] IDX_SCRATCH = 13'h0001;
    localparam logic [12:0] IDX_CTRL    = 13'h0002;
    localparam logic [12:0] IDX_STATUS  = 13'h0003;
    localparam logic [12:0] IDX_PULSE   = 13'h0004;
    localparam logic [12:0] IDX_CYCLES  = 13'h0005;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    // Expand byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Replace only the masked bits of an old register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // True for any word index that has a register behind it.
    function automatic logic is_mapped(input logic [12:0] idx);
        logic hit;
        case (idx)
            IDX_ID, IDX_SCRATCH, IDX_CTRL, IDX_STATUS, IDX_PULSE, IDX_CYCLES: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Write channel state
    logic        aw_held_r;
    logic        w_held_r;
    logic [12:0] aw_idx_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        bvalid_r;
    logic [1:0]  bresp_r;

    // Read channel state
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic [1:0]  rresp_r;

    // Register file
    logic [31:0] scratch_r;
    logic [31:0] ctrl_r;
    logic [31:0] status_r;
    logic [31:0] pulse_r;
    logic [31:0] cycles_r;

    // Combinational helpers
    logic        awready_s;
    logic        wready_s;
    logic        arready_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        ar_hs_s;
    logic        wr_fire_s;
    logic [12:0] wr_idx_s;
    logic [31:0] wr_data_s;
    logic [31:0] wr_mask_s;
    logic [31:0] rd_data_s;
    logic [1:0]  rd_resp_s;

    // Handshake qualifiers; a write fires on the edge that completes the AW/W pair.
    always_comb begin
        awready_s = !aw_held_r && !bvalid_r;
        wready_s  = !w_held_r && !bvalid_r;
        arready_s = !rvalid_r;
        aw_hs_s   = bus.s_awvalid && awready_s;
        w_hs_s    = bus.s_wvalid && wready_s;
        ar_hs_s   = bus.s_arvalid && arready_s;
        wr_fire_s = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
    end

    // Select the write address/data from the latched copy or the live bus.
    always_comb begin
        wr_idx_s  = 13'h0000;
        wr_data_s = 32'h0000_0000;
        wr_mask_s = 32'h0000_0000;
        if (aw_held_r) begin
            wr_idx_s = aw_idx_r;
        end else begin
            wr_idx_s = bus.s_awaddr[14:2];
        end
        if (w_held_r) begin
            wr_data_s = wdata_r;
            wr_mask_s = strb_mask(wstrb_r);
        end else begin
            wr_data_s = bus.s_wdata;
            wr_mask_s = strb_mask(bus.s_wstrb);
        end
    end

    // Read address decode against current (pre-write) register contents.
    always_comb begin
        rd_data_s = UNMAPPED_DATA;
        rd_resp_s = RESP_SLVERR;
        case (bus.s_araddr[14:2])
            IDX_ID:      begin rd_data_s = ID_VALUE;      rd_resp_s = RESP_OKAY; end
            IDX_SCRATCH: begin rd_data_s = scratch_r;     rd_resp_s = RESP_OKAY; end
            IDX_CTRL:    begin rd_data_s = ctrl_r;        rd_resp_s = RESP_OKAY; end
            IDX_STATUS:  begin rd_data_s = status_r;      rd_resp_s = RESP_OKAY; end
            IDX_PULSE:   begin rd_data_s = 32'h0000_0000; rd_resp_s = RESP_OKAY; end
            IDX_CYCLES:  begin rd_data_s = cycles_r;      rd_resp_s = RESP_OKAY; end
            default:     begin rd_data_s = UNMAPPED_DATA; rd_resp_s = RESP_SLVERR; end
        endcase
    end

    // Write channel: latch AW/W independently, raise B when the pair completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_idx_r  <= 13'h0000;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'h0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else if (wr_fire_s) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= is_mapped(wr_idx_s) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                aw_idx_r  <= bus.s_awaddr[14:2];
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                wdata_r  <= bus.s_wdata;
                wstrb_r  <= bus.s_wstrb;
            end
            if (bvalid_r && bus.s_bready) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read channel: capture data on AR handshake, hold until R handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            rresp_r  <= RESP_OKAY;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_resp_s;
        end else if (rvalid_r && bus.s_rready) begin
            rvalid_r <= 1'b0;
        end
    end

    // Register file updates, status sampling, pulse generation and cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch_r <= 32'h0000_0000;
            ctrl_r    <= CTRL_RST;
            status_r  <= 32'h0000_0000;
            pulse_r   <= 32'h0000_0000;
            cycles_r  <= 32'h0000_0000;
        end else begin
            status_r <= status_in;
            if (wr_fire_s && (wr_idx_s == IDX_SCRATCH)) begin
                scratch_r <= merge_bytes(scratch_r, wr_data_s, wr_mask_s);
            end
            if (wr_fire_s && (wr_idx_s == IDX_CTRL)) begin
                ctrl_r <= merge_bytes(ctrl_r, wr_data_s, wr_mask_s);
            end
            if (wr_fire_s && (wr_idx_s == IDX_PULSE)) begin
                pulse_r <= wr_data_s & wr_mask_s;
            end else begin
                pulse_r <= 32'h0000_0000;
            end
            // Clear wins over increment; the counter wraps naturally.
            if (wr_fire_s && (wr_idx_s == IDX_CYCLES)) begin
                cycles_r <= 32'h0000_0000;
            end else begin
                cycles_r <= cycles_r + 32'h0000_0001;
            end
        end
    end

    assign bus.s_awready = awready_s;
    assign bus.s_wready  = wready_s;
    assign bus.s_bvalid  = bvalid_r;
    assign bus.s_bresp   = bresp_r;
    assign bus.s_arready = arready_s;
    assign bus.s_rvalid  = rvalid_r;
    assign bus.s_rdata   = rdata_r;
    assign bus.s_rresp   = rresp_r;
    assign ctrl_out      = ctrl_r;
    assign pulse_out     = pulse_r;

endmodule
